// File: rtl/decode_stage.sv
// Instruction-decode stage: splits op/funct, registers the decoded control bundle with PC/insn,
// and hands it downstream through a main register backed by a one-entry skid register.
module decode_stage #(
    parameter int INSN_W = 32,  // must be >= 32: op = insn[31:26], funct = insn[5:0]
    parameter int PC_W   = 32,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [INSN_W-1:0] in_insn,
    input  logic [PC_W-1:0]   in_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [INSN_W-1:0] out_insn,
    output logic [PC_W-1:0]   out_pc,
    output logic              do_calc,
    output logic [4:0]        alu_op,
    output logic              do_shift,
    output logic              do_movz,
    output logic              do_mem_read,
    output logic              do_mem_write,
    output logic              do_cmp,
    output logic              do_bit_test,
    output logic              do_jump,
    output logic              illegal,
    output logic [CNT_W-1:0]  illegal_cnt
);

    typedef struct packed {
        logic       do_calc;
        logic [4:0] alu_op;
        logic       do_shift;
        logic       do_movz;
        logic       do_mem_read;
        logic       do_mem_write;
        logic       do_cmp;
        logic       do_bit_test;
        logic       do_jump;
        logic       illegal;
    } bundle_t;

    logic [5:0] op;
    logic [5:0] funct;
    bundle_t    in_bnd;

    assign op    = in_insn[31:26];
    assign funct = in_insn[5:0];

    // Exactly one class bit ends up set; anything unmatched falls to illegal.
    always_comb begin
        in_bnd = '0;
        case (op)
            6'b000000: begin
                case (funct)
                    6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100110: begin
                        in_bnd.do_calc = 1'b1;
                        in_bnd.alu_op  = funct[4:0];
                    end
                    6'b000000: in_bnd.do_shift = 1'b1;
                    6'b001010: in_bnd.do_movz  = 1'b1;
                    default:   in_bnd.illegal  = 1'b1;
                endcase
            end
            6'b100011: in_bnd.do_mem_read  = 1'b1;
            6'b101011: in_bnd.do_mem_write = 1'b1;
            6'b111110: in_bnd.do_cmp       = 1'b1;
            6'b111111: in_bnd.do_bit_test  = 1'b1;
            6'b000010: in_bnd.do_jump      = 1'b1;
            default:   in_bnd.illegal      = 1'b1;
        endcase
    end

    // Handshake: a transfer happens on a rising edge where valid and ready are both high.
    // in_ready depends only on skid occupancy, so it is a register output with no
    // combinational path from out_ready; out_* hold steady while out_valid & ~out_ready.
    logic              m_valid_q, m_valid_d;
    logic [INSN_W-1:0] m_insn_q, m_insn_d;
    logic [PC_W-1:0]   m_pc_q, m_pc_d;
    bundle_t           m_bnd_q, m_bnd_d;
    logic              s_valid_q, s_valid_d;
    logic [INSN_W-1:0] s_insn_q, s_insn_d;
    logic [PC_W-1:0]   s_pc_q, s_pc_d;
    bundle_t           s_bnd_q, s_bnd_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              accept;
    logic              pop;

    assign accept = in_valid & ~s_valid_q;
    assign pop    = m_valid_q & out_ready;

    always_comb begin
        m_valid_d = m_valid_q;
        m_insn_d  = m_insn_q;
        m_pc_d    = m_pc_q;
        m_bnd_d   = m_bnd_q;
        s_valid_d = s_valid_q;
        s_insn_d  = s_insn_q;
        s_pc_d    = s_pc_q;
        s_bnd_d   = s_bnd_q;
        cnt_d     = cnt_q;

        // Counting happens even when a flush drops the accepted word.
        if (accept && in_bnd.illegal && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        if (flush) begin
            m_valid_d = 1'b0;
            s_valid_d = 1'b0;
        end else if (!m_valid_q || pop) begin
            if (s_valid_q) begin
                m_valid_d = 1'b1;
                m_insn_d  = s_insn_q;
                m_pc_d    = s_pc_q;
                m_bnd_d   = s_bnd_q;
                s_valid_d = accept;
                s_insn_d  = in_insn;
                s_pc_d    = in_pc;
                s_bnd_d   = in_bnd;
            end else if (accept) begin
                m_valid_d = 1'b1;
                m_insn_d  = in_insn;
                m_pc_d    = in_pc;
                m_bnd_d   = in_bnd;
            end else begin
                m_valid_d = 1'b0;
            end
        end else if (accept) begin
            s_valid_d = 1'b1;
            s_insn_d  = in_insn;
            s_pc_d    = in_pc;
            s_bnd_d   = in_bnd;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid_q <= 1'b0;
            m_insn_q  <= '0;
            m_pc_q    <= '0;
            m_bnd_q   <= '0;
            s_valid_q <= 1'b0;
            s_insn_q  <= '0;
            s_pc_q    <= '0;
            s_bnd_q   <= '0;
            cnt_q     <= '0;
        end else begin
            m_valid_q <= m_valid_d;
            m_insn_q  <= m_insn_d;
            m_pc_q    <= m_pc_d;
            m_bnd_q   <= m_bnd_d;
            s_valid_q <= s_valid_d;
            s_insn_q  <= s_insn_d;
            s_pc_q    <= s_pc_d;
            s_bnd_q   <= s_bnd_d;
            cnt_q     <= cnt_d;
        end
    end

    bundle_t out_bnd;

    assign out_bnd      = m_valid_q ? m_bnd_q : '0;
    assign in_ready     = ~s_valid_q;
    assign out_valid    = m_valid_q;
    assign out_insn     = m_insn_q;
    assign out_pc       = m_pc_q;
    assign do_calc      = out_bnd.do_calc;
    assign alu_op       = out_bnd.alu_op;
    assign do_shift     = out_bnd.do_shift;
    assign do_movz      = out_bnd.do_movz;
    assign do_mem_read  = out_bnd.do_mem_read;
    assign do_mem_write = out_bnd.do_mem_write;
    assign do_cmp       = out_bnd.do_cmp;
    assign do_bit_test  = out_bnd.do_bit_test;
    assign do_jump      = out_bnd.do_jump;
    assign illegal      = out_bnd.illegal;
    assign illegal_cnt  = cnt_q;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed scenarios followed by random traffic, checked against a
// two-deep in-order queue model with a table-style decoder.
module tb_decode_stage;

    localparam int CNT_W   = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0]      in_insn, in_pc, out_insn, out_pc;
    logic             do_calc, do_shift, do_movz, do_mem_read, do_mem_write;
    logic             do_cmp, do_bit_test, do_jump, illegal;
    logic [4:0]       alu_op;
    logic [CNT_W-1:0] illegal_cnt;
    logic [13:0]      got_bnd;

    decode_stage #(.INSN_W(32), .PC_W(32), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_insn(in_insn), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_insn(out_insn), .out_pc(out_pc),
        .do_calc(do_calc), .alu_op(alu_op), .do_shift(do_shift), .do_movz(do_movz),
        .do_mem_read(do_mem_read), .do_mem_write(do_mem_write), .do_cmp(do_cmp),
        .do_bit_test(do_bit_test), .do_jump(do_jump), .illegal(illegal),
        .illegal_cnt(illegal_cnt)
    );

    assign got_bnd = {do_calc, alu_op, do_shift, do_movz, do_mem_read, do_mem_write,
                      do_cmp, do_bit_test, do_jump, illegal};

    // ---------------- scoreboard ----------------
    logic [63:0] exp_q[$];   // {pc, insn}, head is what the outputs must show
    int          exp_cnt;
    bit          after_rst;
    bit          last_acc;
    int          n_checks;
    int          n_pass;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic logic [13:0] ref_decode(input logic [31:0] w);
        logic [5:0]  op, f;
        string       kind;
        logic [13:0] r;
        op   = w[31:26];
        f    = w[5:0];
        kind = "illegal";
        if (op == 6'd0) begin
            if (f inside {6'd32, 6'd34, 6'd36, 6'd37, 6'd38}) kind = "calc";
            else if (f == 6'd0)  kind = "shift";
            else if (f == 6'd10) kind = "movz";
        end
        else if (op == 6'd35) kind = "lw";
        else if (op == 6'd43) kind = "sw";
        else if (op == 6'd62) kind = "cmp";
        else if (op == 6'd63) kind = "bbt";
        else if (op == 6'd2)  kind = "jump";
        r = '0;
        case (kind)
            "calc":  begin r[13] = 1'b1; r[12:8] = f[4:0]; end
            "shift": r[7] = 1'b1;
            "movz":  r[6] = 1'b1;
            "lw":    r[5] = 1'b1;
            "sw":    r[4] = 1'b1;
            "cmp":   r[3] = 1'b1;
            "bbt":   r[2] = 1'b1;
            "jump":  r[1] = 1'b1;
            default: r[0] = 1'b1;
        endcase
        return r;
    endfunction

    task automatic check_outputs();
        check("in_ready", 64'(in_ready), 64'(exp_q.size() < 2));
        check("out_valid", 64'(out_valid), 64'(exp_q.size() > 0));
        check("illegal_cnt", 64'(illegal_cnt), 64'(exp_cnt));
        if (exp_q.size() > 0) begin
            check("out_pc", 64'(out_pc), 64'(exp_q[0][63:32]));
            check("out_insn", 64'(out_insn), 64'(exp_q[0][31:0]));
            check("bundle", 64'(got_bnd), 64'(ref_decode(exp_q[0][31:0])));
        end else begin
            check("bundle_idle", 64'(got_bnd), 64'd0);
            if (after_rst) begin
                check("out_pc_rst", 64'(out_pc), 64'd0);
                check("out_insn_rst", 64'(out_insn), 64'd0);
            end
        end
    endtask

    // ---------------- driver ----------------
    // One clock: check the state left by the previous edge, drive new inputs, advance the model.
    task automatic cycle(input logic r, input logic f, input logic v, input logic rdy,
                         input logic [31:0] insn, input logic [31:0] pc);
        logic        acc;
        logic [13:0] b;
        @(negedge clk);
        check_outputs();
        rst       = r;
        flush     = f;
        in_valid  = v;
        out_ready = rdy;
        in_insn   = insn;
        in_pc     = pc;
        acc       = v && (exp_q.size() < 2) && !r;
        last_acc  = acc;
        b         = ref_decode(insn);
        if (r) begin
            exp_q.delete();
            exp_cnt   = 0;
            after_rst = 1'b1;
        end else begin
            if (acc && b[0] && exp_cnt < CNT_MAX) exp_cnt++;
            if (acc) after_rst = 1'b0;
            if (f) begin
                exp_q.delete();
            end else begin
                if (exp_q.size() > 0 && rdy) void'(exp_q.pop_front());
                if (acc) exp_q.push_back({pc, insn});
            end
        end
    endtask

    task automatic send(input logic [31:0] insn, input logic [31:0] pc, input logic rdy);
        cycle(1'b0, 1'b0, 1'b1, rdy, insn, pc);
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, rdy, 32'h0, 32'h0);
    endtask

    // Holds a word valid until the model takes it, with a cycle bound.
    task automatic send_hold(input logic [31:0] insn, input logic [31:0] pc, input logic rdy);
        int guard;
        guard = 0;
        do begin
            send(insn, pc, rdy);
            guard++;
        end while (!last_acc && guard < 20);
        check("hold_accepted", 64'(last_acc), 64'd1);
    endtask

    logic [5:0] r_ops[5]   = '{6'd35, 6'd43, 6'd62, 6'd63, 6'd2};
    logic [5:0] r_functs[7] = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd38, 6'd0, 6'd10};

    function automatic logic [31:0] rand_insn();
        logic [31:0] w;
        w = $urandom;
        case ($urandom_range(0, 3))
            0: ;
            1: begin w[31:26] = 6'd0; w[5:0] = r_functs[$urandom_range(0, 6)]; end
            2: w[31:26] = r_ops[$urandom_range(0, 4)];
            default: w = (w & 32'h03FF_FFC0) | 32'h0000_0000;
        endcase
        return w;
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        logic        pend;
        logic [31:0] p_insn, p_pc;
        n_checks  = 0;
        n_pass    = 0;
        exp_cnt   = 0;
        after_rst = 1'b1;
        last_acc  = 1'b0;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_insn = '0; in_pc = '0;

        cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        idle(1, 1'b1);
        // ADD then drain
        send(32'h00A62020, 32'h100, 1'b1);
        idle(2, 1'b1);
        // back-to-back stream
        send(32'h8C220004, 32'h104, 1'b1);
        send(32'hAC220004, 32'h108, 1'b1);
        send(32'h08000010, 32'h10C, 1'b1);
        idle(2, 1'b1);
        // back-pressure: second lands in skid, third waits upstream
        send(32'h00851822, 32'h200, 1'b0);
        send(32'h00851824, 32'h204, 1'b0);
        send(32'h0085180A, 32'h208, 1'b0);
        send(32'h0085180A, 32'h208, 1'b0);
        send_hold(32'h0085180A, 32'h208, 1'b1);
        idle(3, 1'b1);
        // BBT, illegal counting and saturation
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
        send(32'hFC000000, 32'h300, 1'b1);
        send(32'h04000000, 32'h304, 1'b1);
        for (int i = 0; i < 5; i++) send(32'h04000000 | 32'(i), 32'h308 + 32'(4 * i), 1'b1);
        send(32'hF8000000, 32'h320, 1'b1);
        idle(2, 1'b1);
        // flush with M and S full and a word offered the same cycle
        send(32'h00A62025, 32'h400, 1'b0);
        send(32'h00A62026, 32'h404, 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h00000000, 32'h408);
        idle(3, 1'b1);
        // reset in the middle of traffic
        send(32'h7C000000, 32'h500, 1'b0);
        send(32'h00000000, 32'h504, 1'b0);
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 32'h8C220004, 32'h508);
        idle(2, 1'b1);

        // random traffic
        pend   = 1'b0;
        p_insn = '0;
        p_pc   = 32'h1000;
        for (int n = 0; n < 2500; n++) begin
            logic r, f, rdy;
            r   = ($urandom_range(0, 199) == 0);
            f   = ($urandom_range(0, 39) == 0);
            rdy = ($urandom_range(0, 9) < 6);
            if (!pend && $urandom_range(0, 9) < 7) begin
                pend   = 1'b1;
                p_insn = rand_insn();
                p_pc   = p_pc + 32'd4;
            end
            cycle(r, f, pend, rdy, p_insn, p_pc);
            if (last_acc || r) pend = 1'b0;
        end

        @(negedge clk);
        check_outputs();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
